// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall/bubble/flush controller with pending-flush latch and stall watchdog.
// Optional stall-cycle performance counter enabled by defining STALL_PERF_EN.
module pipe_stall_ctrl #(
    parameter int STAGES = 5,
    parameter int WDOG_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [STAGES-1:0] stall_rq_i,
    input  logic [STAGES-1:0] flush_rq_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] bubble_o,
    output logic [STAGES-1:0] flush_o,
    output logic              flush_pend_o,
    output logic              stuck_o,
    input  logic              perf_clr_i,
    output logic [31:0]       stall_cyc_o
);
    localparam int IW = $clog2(STAGES);
    logic              pend_vld_q, pend_vld_d;
    logic [IW-1:0]     pend_idx_q, pend_idx_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [IW-1:0]     stall_idx, new_idx, fl_idx;
    logic              stall_hit, new_hit, fl_hit, fl_eff, frz;
    logic [STAGES-1:0] st_v, bu_v, fl_v;
    always_comb begin
        stall_idx = '0;
        new_idx   = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (stall_rq_i[i]) stall_idx = IW'(i);
            if (flush_rq_i[i]) new_idx = IW'(i);
        end
        stall_hit = |stall_rq_i;
        new_hit   = |flush_rq_i;
        fl_hit    = new_hit | pend_vld_q;
        fl_idx    = (pend_vld_q && (!new_hit || pend_idx_q > new_idx)) ? pend_idx_q : new_idx;
        // A flush is only blocked by a stall in an older stage than the flush source
        fl_eff    = fl_hit && rdy_in && !(stall_hit && stall_idx > fl_idx);
        for (int j = 0; j < STAGES; j++) begin
            st_v[j] = stall_hit && IW'(j) <= stall_idx && !(fl_eff && IW'(j) <= fl_idx);
            bu_v[j] = stall_hit && IW'(j) == stall_idx && !(fl_eff && IW'(j) <= fl_idx);
            fl_v[j] = fl_eff && IW'(j) < fl_idx;
        end
    end
    assign frz          = rst_in | ~rdy_in;
    assign stall_o      = frz ? '1 : st_v;
    assign bubble_o     = frz ? '0 : bu_v;
    assign flush_o      = frz ? '0 : fl_v;
    assign flush_pend_o = ~rst_in & pend_vld_q;
    assign stuck_o      = ~rst_in & (&wdog_q);
    assign pend_vld_d   = rdy_in ? (fl_hit & ~fl_eff) : pend_vld_q;
    assign pend_idx_d   = (rdy_in && fl_hit && !fl_eff) ? fl_idx : pend_idx_q;
    assign wdog_d       = !(|stall_o) ? '0 : (&wdog_q) ? wdog_q : wdog_q + 1'b1;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            wdog_q     <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            wdog_q     <= wdog_d;
        end
    end
`ifdef STALL_PERF_EN
    logic [31:0] perf_q, perf_d;
    assign perf_d      = perf_clr_i ? '0 : (rdy_in && stall_o[0]) ? perf_q + 32'd1 : perf_q;
    assign stall_cyc_o = rst_in ? '0 : perf_q;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) perf_q <= '0;
        else perf_q <= perf_d;
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr_i;
    assign stall_cyc_o     = '0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: scoreboard bench for pipe_stall_ctrl with directed and random stimulus.
module tb_pipe_stall_ctrl;
    localparam int S  = 5;
    localparam int WW = 3;
    localparam int WMAX = (1 << WW) - 1;
    localparam int ALL = (1 << S) - 1;

    logic         clk = 0, rst = 1, rdy = 1, pclr = 0;
    logic [S-1:0] srq = '0, frq = '0;
    logic [S-1:0] stall_o, bubble_o, flush_o;
    logic         pend_o, stuck_o;
    logic [31:0]  cyc_o;

    pipe_stall_ctrl #(.STAGES(S), .WDOG_W(WW)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .stall_rq_i(srq), .flush_rq_i(frq),
        .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
        .flush_pend_o(pend_o), .stuck_o(stuck_o),
        .perf_clr_i(pclr), .stall_cyc_o(cyc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st, bu, fl, pend, stuck;
        longint cyc;
    } exp_t;
    exp_t q[$];

    int compared = 0, mismatched = 0;
    int m_pend = -1, m_wd = 0;
    longint m_perf = 0;

    function automatic int hi(input int v);
        for (int i = S - 1; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int lowmask(input int n);
        return (1 << n) - 1;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic y, input int s, input int f, input logic c);
        exp_t e;
        int k, fn, ff;
        bit eff;
        @(posedge clk);
        #1;
        rst = r; rdy = y; srq = S'(s); frq = S'(f); pclr = c;
        if (r) begin
            e = '{ALL, 0, 0, 0, 0, 0};
            m_pend = -1; m_wd = 0; m_perf = 0;
        end else begin
            k  = hi(s);
            fn = hi(f);
            ff = (fn > m_pend) ? fn : m_pend;
            eff = y && ff >= 0 && k <= ff;
            e.pend  = (m_pend >= 0);
            e.stuck = (m_wd == WMAX);
            e.cyc   = m_perf;
            if (!y) begin
                e.st = ALL; e.bu = 0; e.fl = 0;
            end else begin
                e.st = (k >= 0) ? lowmask(k + 1) : 0;
                e.bu = (k >= 0) ? (1 << k) : 0;
                e.fl = 0;
                if (eff) begin
                    e.fl = lowmask(ff);
                    e.st = e.st & ~lowmask(ff + 1);
                    e.bu = e.bu & ~lowmask(ff + 1);
                end
            end
            if (y) m_pend = eff ? -1 : ff;
            m_wd = (e.st != 0) ? ((m_wd + 1 > WMAX) ? WMAX : m_wd + 1) : 0;
`ifdef STALL_PERF_EN
            m_perf = c ? 0 : (y && e.st[0]) ? ((m_perf + 1) & 64'hFFFF_FFFF) : m_perf;
`else
            m_perf = 0;
`endif
        end
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall_o", longint'(stall_o), longint'(e.st));
                chk("bubble_o", longint'(bubble_o), longint'(e.bu));
                chk("flush_o", longint'(flush_o), longint'(e.fl));
                chk("flush_pend_o", longint'(pend_o), longint'(e.pend));
                chk("stuck_o", longint'(stuck_o), longint'(e.stuck));
                chk("stall_cyc_o", longint'(cyc_o), e.cyc);
            end
        end
    end

    initial begin : driver
        step(1, 1, 0, 0, 0);
        step(1, 1, 5'b10101, 5'b01010, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 5'b00100, 0, 0);
        step(0, 1, 5'b00000, 0, 0);
        step(0, 1, 5'b10000, 5'b00010, 0);
        step(0, 1, 5'b10000, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 5'b10000, 5'b00010, 0);
        step(0, 1, 5'b10000, 5'b01000, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 5'b00100, 5'b01000, 0);
        step(0, 1, 5'b01000, 5'b01000, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 5'b00001, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 5'b00100, 5'b00010, 0);
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 5'b00001, 0, 0);
        step(0, 1, 5'b10000, 5'b00100, 0);
        step(0, 1, 5'b10000, 0, 0);
        step(1, 1, 5'b10000, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 9) != 0,
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, ALL)) : 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ALL)) : 0,
                 $urandom_range(0, 19) == 0);
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter STAGES, default 5; number of pipeline stages (stage 0 = IF, stage STAGES-1 = oldest), legal range 2..16.
REQ-002 Parameter WDOG_W, default 8; width of the consecutive-stall watchdog counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 rdy_in  input  1  global ready; low freezes the whole pipeline.
REQ-007 stall_rq_i  input  STAGES  bit k: stage k cannot complete this cycle.
REQ-008 flush_rq_i  input  STAGES  bit k: stage k has resolved a redirect; younger stages are invalid.
REQ-009 stall_o  output  STAGES  bit j: hold stage j and its input register.
REQ-010 bubble_o  output  STAGES  bit j: load a bubble into the register after stage j.
REQ-011 flush_o  output  STAGES  bit j: clear the register after stage j.
REQ-012 flush_pend_o  output  1  a latched flush is waiting to be applied.
REQ-013 stuck_o  output  1  watchdog counter saturated.
REQ-014 perf_clr_i  input  1  synchronous clear of the performance counter.
REQ-015 stall_cyc_o  output  32  stall-cycle performance count.

Function
REQ-016 Stall source: the highest index k with stall_rq_i[k]=1 SHALL win.
- stall_o[j]=1 for all j<=k.
- bubble_o[k]=1.
- All other bits 0.
REQ-017 rdy_in=0 SHALL force stall_o all ones and bubble_o/flush_o all zeros, overriding every request; internal state holds except the watchdog.
REQ-018 A flush request from stage f (highest set bit) SHALL be effective when rdy_in=1 and no stall_rq_i bit above f is set.
- flush_o[j]=1 for all j<f.
- stall_o[j]=0 and bubble_o[j]=0 for all j<=f.
REQ-019 A flush request that is not effective SHALL be latched into a pending register (index f, valid bit).
- flush_pend_o=1 from the next cycle.
- If the register already holds an index, the higher of the held and new index is kept.
REQ-020 A pending flush SHALL be applied combinationally per REQ-018 in the first cycle its condition holds, then cleared at that edge.
- A simultaneous new flush_rq_i merges by taking the higher index.
REQ-021 With no stalls and no flushes, all stall_o/bubble_o/flush_o bits SHALL be 0.
REQ-022 Watchdog counter behaviour.
- Increments each cycle any stall_o bit is 1, including rdy_in=0 cycles.
- Clears to 0 on any cycle with stall_o all zeros.
- Saturates at 2^WDOG_W-1 without wrapping.
- stuck_o=1 exactly while saturated.
REQ-023 All outputs SHALL be combinational from inputs and registered state, with zero-cycle latency from requests.

Reset
REQ-024 While rst_in=1, every output SHALL be driven as follows.
- stall_o: all ones.
- bubble_o, flush_o, flush_pend_o, stuck_o, stall_cyc_o: 0.
REQ-025 Reset SHALL clear the pending-flush register, watchdog counter and performance counter immediately, including mid-stall and mid-pending-flush.

Configuration
REQ-026 Macro STALL_PERF_EN defined: stall_cyc_o counts cycles with rdy_in=1 and stall_o[0]=1.
- Wraps at 2^32.
- perf_clr_i=1 loads 0 and takes priority over the increment.
REQ-027 Macro STALL_PERF_EN undefined: no counter is built, stall_cyc_o is tied 0, and perf_clr_i is ignored.

Verification
REQ-028 STAGES=5: stall_rq_i=5'b00100 and rdy_in=1 -> stall_o=00111, bubble_o=00100, flush_o=0.
REQ-029 STAGES=5: stall_rq_i=10000 and flush_rq_i=00010 in the same cycle.
- That cycle: stall_o=11111, flush_o=0.
- Next cycle: flush_pend_o=1.
- When stall_rq_i drops to 0: flush_o=00001 that cycle, then flush_pend_o=0.
REQ-030 Pending flush index 1, then flush_rq_i=01000 arrives while still blocked -> on release flush_o=00111.
REQ-031 WDOG_W=3: stall_rq_i[0] held 7 cycles -> stuck_o=1 from the 7th edge and held while stalling; one stall-free cycle -> counter 0, stuck_o=0.
REQ-032 rdy_in=0 with stall_rq_i=0 -> stall_o all ones; with STALL_PERF_EN, stall_cyc_o is unchanged during that period.
REQ-033 rst_in pulsed mid-pending-flush with the counter at 20 -> flush_pend_o=0, stall_cyc_o=0, stuck_o=0 before the next edge.
